// File: rtl/d_bus_xbar.sv
// d_bus_xbar: single-master, N-slave data-bus decoder with registered slave
// requests, per-access timeout, error responses and error capture.
module d_bus_xbar #(
    parameter int unsigned               XLEN     = 32,
    parameter int unsigned               ADDR_LEN = 16,
    parameter int unsigned               N_SLV    = 4,
    parameter logic [N_SLV*ADDR_LEN-1:0] SLV_BASE = '0,
    parameter logic [N_SLV*ADDR_LEN-1:0] SLV_MASK = '1,
    parameter int unsigned               TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [ADDR_LEN-1:0]   addr,
    input  logic                  rd_req,
    input  logic                  wr_req,
    input  logic [XLEN/8-1:0]     be,
    input  logic [XLEN-1:0]       wr_data,
    output logic                  rd_ready,
    output logic                  wr_ready,
    output logic [XLEN-1:0]       rd_data,
    output logic                  err,
    output logic [ADDR_LEN-1:0]   s_addr,
    output logic [N_SLV-1:0]      s_rd_req,
    output logic [N_SLV-1:0]      s_wr_req,
    output logic [XLEN/8-1:0]     s_be,
    output logic [XLEN-1:0]       s_wr_data,
    input  logic [N_SLV*XLEN-1:0] s_rd_data,
    input  logic [N_SLV-1:0]      s_rd_ready,
    input  logic [N_SLV-1:0]      s_wr_ready,
    output logic [ADDR_LEN-1:0]   err_addr,
    output logic [7:0]            err_cnt
);

    localparam int unsigned BE_W     = XLEN / 8;
    localparam int unsigned OFS_BITS = $clog2(BE_W);
    localparam int unsigned SEL_W    = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int unsigned TMR_W    = 16;
    localparam logic [ADDR_LEN-1:0] ALIGN_MASK = ~ADDR_LEN'((1 << OFS_BITS) - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 is_wr_q, is_wr_d;
    logic [ADDR_LEN-1:0]  addr_q, addr_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [ADDR_LEN-1:0]  s_addr_d;
    logic [BE_W-1:0]      s_be_d;
    logic [XLEN-1:0]      s_wr_data_d;
    logic [N_SLV-1:0]     s_rd_req_d, s_wr_req_d;
    logic                 rd_ready_d, wr_ready_d, err_d;
    logic [XLEN-1:0]      rd_data_d;
    logic [ADDR_LEN-1:0]  err_addr_d;
    logic [7:0]           err_cnt_d;

    logic                 hit;
    logic [SEL_W-1:0]     hit_sel;
    logic [ADDR_LEN-1:0]  hit_ofs;
    logic [N_SLV-1:0]     hit_vec, sel_vec;
    logic                 sel_done, timed_out;
    logic [XLEN-1:0]      sel_rdata;
    logic [7:0]           err_cnt_inc;

    // Address decode: the lowest-numbered matching slot wins
    always_comb begin
        hit     = 1'b0;
        hit_sel = '0;
        hit_ofs = '0;
        for (int unsigned k = 0; k < N_SLV; k++) begin
            if (!hit && ((addr & SLV_MASK[k*ADDR_LEN +: ADDR_LEN]) ==
                         SLV_BASE[k*ADDR_LEN +: ADDR_LEN])) begin
                hit     = 1'b1;
                hit_sel = SEL_W'(k);
                hit_ofs = addr & ~SLV_MASK[k*ADDR_LEN +: ADDR_LEN] & ALIGN_MASK;
            end
        end
    end

    assign hit_vec     = N_SLV'(1) << hit_sel;
    assign sel_vec     = N_SLV'(1) << sel_q;
    assign sel_rdata   = s_rd_data[sel_q*XLEN +: XLEN];
    assign sel_done    = is_wr_q ? s_wr_ready[sel_q] : s_rd_ready[sel_q];
    assign timed_out   = (TIMEOUT != 0) && (timer_q == TMR_W'(TIMEOUT - 1));
    assign err_cnt_inc = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

    // Next-state and next-output logic; every output is registered
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        is_wr_d     = is_wr_q;
        addr_d      = addr_q;
        timer_d     = timer_q;
        s_addr_d    = s_addr;
        s_be_d      = s_be;
        s_wr_data_d = s_wr_data;
        s_rd_req_d  = '0;
        s_wr_req_d  = '0;
        rd_ready_d  = 1'b0;
        wr_ready_d  = 1'b0;
        err_d       = 1'b0;
        rd_data_d   = '0;
        err_addr_d  = err_addr;
        err_cnt_d   = err_cnt;
        case (state_q)
            IDLE: begin
                if (rd_req || wr_req) begin
                    is_wr_d     = wr_req;
                    addr_d      = addr;
                    sel_d       = hit_sel;
                    s_addr_d    = hit_ofs;
                    s_be_d      = be;
                    s_wr_data_d = wr_data;
                    timer_d     = '0;
                    if (hit) begin
                        state_d = ACCESS;
                        if (wr_req) s_wr_req_d = hit_vec;
                        else        s_rd_req_d = hit_vec;
                    end else begin
                        state_d    = ERR;
                        rd_ready_d = !wr_req;
                        wr_ready_d = wr_req;
                        err_d      = 1'b1;
                        err_addr_d = addr;
                        err_cnt_d  = err_cnt_inc;
                    end
                end
            end
            ACCESS: begin
                timer_d = timer_q + TMR_W'(1);
                // A ready on the final timeout cycle still completes normally
                if (sel_done) begin
                    state_d    = DONE;
                    rd_ready_d = !is_wr_q;
                    wr_ready_d = is_wr_q;
                    if (!is_wr_q) rd_data_d = sel_rdata;
                end else if (timed_out) begin
                    state_d    = ERR;
                    rd_ready_d = !is_wr_q;
                    wr_ready_d = is_wr_q;
                    err_d      = 1'b1;
                    err_addr_d = addr_q;
                    err_cnt_d  = err_cnt_inc;
                end else begin
                    if (is_wr_q) s_wr_req_d = sel_vec;
                    else         s_rd_req_d = sel_vec;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            timer_q   <= '0;
            s_addr    <= '0;
            s_be      <= '0;
            s_wr_data <= '0;
            s_rd_req  <= '0;
            s_wr_req  <= '0;
            rd_ready  <= 1'b0;
            wr_ready  <= 1'b0;
            err       <= 1'b0;
            rd_data   <= '0;
            err_addr  <= '0;
            err_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            timer_q   <= timer_d;
            s_addr    <= s_addr_d;
            s_be      <= s_be_d;
            s_wr_data <= s_wr_data_d;
            s_rd_req  <= s_rd_req_d;
            s_wr_req  <= s_wr_req_d;
            rd_ready  <= rd_ready_d;
            wr_ready  <= wr_ready_d;
            err       <= err_d;
            rd_data   <= rd_data_d;
            err_addr  <= err_addr_d;
            err_cnt   <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_d_bus_xbar.sv
// Scoreboard bench for d_bus_xbar: directed accesses push expected master
// responses and slave requests; negedge monitors pop and compare.
module tb_d_bus_xbar;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned ADDR_LEN = 16;
    localparam int unsigned N_SLV    = 4;
    localparam int unsigned TIMEOUT  = 4;
    localparam logic [63:0] BASE = {16'hC000, 16'h8000, 16'h4000, 16'h8000};
    localparam logic [63:0] MASK = {16'hF000, 16'hC000, 16'hC000, 16'hF000};

    typedef struct {
        logic        wr;
        logic        er;
        logic [31:0] rd;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic        wr;
        logic [3:0]  vec;
        logic [15:0] sa;
        logic [3:0]  be;
        logic [31:0] wd;
        int          cyc;
        int          len;
    } sreq_t;

    logic         clk = 1'b0;
    logic         rstb;
    logic [15:0]  addr;
    logic         rd_req, wr_req;
    logic [3:0]   be;
    logic [31:0]  wr_data;
    logic         rd_ready, wr_ready, err;
    logic [31:0]  rd_data;
    logic [15:0]  s_addr;
    logic [3:0]   s_rd_req, s_wr_req;
    logic [3:0]   s_be;
    logic [31:0]  s_wr_data;
    logic [127:0] s_rd_data;
    logic [3:0]   s_rd_ready, s_wr_ready;
    logic [15:0]  err_addr;
    logic [7:0]   err_cnt;

    d_bus_xbar #(
        .XLEN(XLEN), .ADDR_LEN(ADDR_LEN), .N_SLV(N_SLV),
        .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rstb(rstb), .addr(addr), .rd_req(rd_req), .wr_req(wr_req),
        .be(be), .wr_data(wr_data), .rd_ready(rd_ready), .wr_ready(wr_ready),
        .rd_data(rd_data), .err(err), .s_addr(s_addr), .s_rd_req(s_rd_req),
        .s_wr_req(s_wr_req), .s_be(s_be), .s_wr_data(s_wr_data),
        .s_rd_data(s_rd_data), .s_rd_ready(s_rd_ready), .s_wr_ready(s_wr_ready),
        .err_addr(err_addr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    rsp_t  rsp_q[$];
    sreq_t sq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Slave responder: ready after rsp_wait request cycles, optional stray ready from slot 2
    int          rsp_wait   = 0;
    bit          rsp_silent = 1'b0;
    bit          stray_en   = 1'b0;
    logic [31:0] rsp_data   = 32'h0;
    int          age        = 0;
    initial begin
        s_rd_ready = '0;
        s_wr_ready = '0;
        s_rd_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            s_rd_ready = '0;
            s_wr_ready = '0;
            for (int k = 0; k < 4; k++)
                s_rd_data[k*32 +: 32] = s_rd_req[k] ? rsp_data : ~rsp_data;
            if ((s_rd_req | s_wr_req) != 4'h0) begin
                if (!rsp_silent && age == rsp_wait) begin
                    s_rd_ready = s_rd_req;
                    s_wr_ready = s_wr_req;
                end
                if (stray_en && age == 0) begin
                    s_rd_ready[2] = 1'b1;
                    s_wr_ready[2] = 1'b1;
                end
                age++;
            end else begin
                age = 0;
            end
        end
    end

    // Master-side monitor
    rsp_t re;
    always @(negedge clk) begin
        if (rstb) begin
            if (rd_ready || wr_ready) begin
                chk("rsp_expected", 32'(rsp_q.size() != 0), 32'h1);
                if (rsp_q.size() != 0) begin
                    re = rsp_q.pop_front();
                    chk("rd_ready", 32'(rd_ready), 32'(!re.wr));
                    chk("wr_ready", 32'(wr_ready), 32'(re.wr));
                    chk("err", 32'(err), 32'(re.er));
                    chk("rd_data", rd_data, re.rd);
                    chk("rsp_cycle", cyc, re.cyc);
                end
            end else begin
                chk("idle_err", 32'(err), 32'h0);
                chk("idle_rd_data", rd_data, 32'h0);
            end
        end
    end

    // Slave-side monitor: request vector, offset, held payload and duration
    bit    s_act  = 1'b0;
    bit    s_have = 1'b0;
    int    s_len  = 0;
    sreq_t se;
    always @(negedge clk) begin
        if (!rstb) begin
            s_act  = 1'b0;
            s_have = 1'b0;
        end else if ((s_rd_req | s_wr_req) != 4'h0) begin
            if (!s_act) begin
                s_act = 1'b1;
                s_len = 0;
                chk("sreq_expected", 32'(sq.size() != 0), 32'h1);
                s_have = 1'b0;
                if (sq.size() != 0) begin
                    se = sq.pop_front();
                    s_have = 1'b1;
                    chk("sreq_cycle", cyc, se.cyc);
                end
            end
            s_len++;
            if (s_have) begin
                chk("s_rd_req", 32'(s_rd_req), se.wr ? 32'h0 : 32'(se.vec));
                chk("s_wr_req", 32'(s_wr_req), se.wr ? 32'(se.vec) : 32'h0);
                chk("s_addr", 32'(s_addr), 32'(se.sa));
                chk("s_be", 32'(s_be), 32'(se.be));
                chk("s_wr_data", s_wr_data, se.wd);
            end
        end else if (s_act) begin
            s_act = 1'b0;
            if (s_have && se.len >= 0) chk("sreq_len", s_len, se.len);
            s_have = 1'b0;
        end
    end

    task automatic do_access(input logic wr, input logic rd, input logic [15:0] a,
                             input logic [3:0] b, input logic [31:0] wd, input int wt,
                             input bit silent, input bit stray, input logic [31:0] rdat,
                             input logic e_err, input int e_lat, input logic [3:0] e_vec,
                             input logic [15:0] e_sa, input int e_len, output int rdy_cyc);
        rsp_t  r;
        sreq_t s;
        bit    seen;
        rsp_wait   = wt;
        rsp_silent = silent;
        stray_en   = stray;
        rsp_data   = rdat;
        r.wr  = wr;
        r.er  = e_err;
        r.rd  = (wr || e_err) ? 32'h0 : rdat;
        r.cyc = cyc + e_lat;
        rsp_q.push_back(r);
        if (e_vec != 4'h0) begin
            s.wr = wr; s.vec = e_vec; s.sa = e_sa; s.be = b; s.wd = wd;
            s.cyc = cyc + 1; s.len = e_len;
            sq.push_back(s);
        end
        addr = a; be = b; wr_data = wd; rd_req = rd; wr_req = wr;
        seen    = 1'b0;
        rdy_cyc = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (rd_ready || wr_ready) begin
                seen    = 1'b1;
                rdy_cyc = cyc;
            end
        end
        chk("ready_seen", 32'(seen), 32'h1);
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        wr_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        int    rc, rc2;
        sreq_t s;
        rstb = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        addr = '0; be = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_ready", 32'(rd_ready), 32'h0);
        chk("rst_wr_ready", 32'(wr_ready), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_s_req", 32'({s_rd_req, s_wr_req}), 32'h0);
        chk("rst_s_addr", 32'(s_addr), 32'h0);
        chk("rst_err_addr", 32'(err_addr), 32'h0);
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);
        @(negedge clk) rstb = 1'b1;
        @(posedge clk);
        #1;

        // read hit, zero wait; write with three wait cycles
        do_access(1'b0, 1'b1, 16'h4008, 4'hF, 32'h0, 0, 0, 0, 32'hDEADBEEF, 0, 2, 4'b0010, 16'h0008, 1, rc);
        do_access(1'b1, 1'b0, 16'h4006, 4'b1100, 32'hA5A50F0F, 3, 0, 0, 32'h0, 0, 5, 4'b0010, 16'h0004, 4, rc);

        // unmapped read
        do_access(1'b0, 1'b1, 16'h1234, 4'hF, 32'h0, 0, 0, 0, 32'h5555AAAA, 1, 1, 4'h0, 16'h0, 0, rc);
        chk("err_addr_unmapped", 32'(err_addr), 32'h1234);
        chk("err_cnt_1", 32'(err_cnt), 32'h1);

        // timeout with silent slave, then ready on the limit cycle
        do_access(1'b1, 1'b0, 16'h4100, 4'hF, 32'h01020304, 0, 1, 0, 32'h0, 1, 5, 4'b0010, 16'h0100, 4, rc);
        chk("err_addr_timeout", 32'(err_addr), 32'h4100);
        chk("err_cnt_2", 32'(err_cnt), 32'h2);
        do_access(1'b1, 1'b0, 16'h4104, 4'h3, 32'h0BADF00D, 3, 0, 0, 32'h0, 0, 5, 4'b0010, 16'h0104, 4, rc);
        chk("err_cnt_still_2", 32'(err_cnt), 32'h2);

        // overlapping slots 0 and 2, then slot 2 alone
        do_access(1'b0, 1'b1, 16'h8010, 4'hF, 32'h0, 0, 0, 0, 32'h12345678, 0, 2, 4'b0001, 16'h0010, 1, rc);
        do_access(1'b0, 1'b1, 16'h9022, 4'hF, 32'h0, 0, 0, 0, 32'h87654321, 0, 2, 4'b0100, 16'h1020, 1, rc);

        // simultaneous read+write performs only the write
        do_access(1'b1, 1'b1, 16'hC00C, 4'hF, 32'hCAFEF00D, 0, 0, 0, 32'h11111111, 0, 2, 4'b1000, 16'h000C, 1, rc);

        // stray ready from slot 2 while slot 1 is waiting
        do_access(1'b0, 1'b1, 16'h4020, 4'hF, 32'h0, 2, 0, 1, 32'h0F0F0F0F, 0, 4, 4'b0010, 16'h0020, 3, rc);

        // back-to-back, second one a be=0 write
        do_access(1'b0, 1'b1, 16'h4030, 4'hF, 32'h0, 0, 0, 0, 32'hAAAA0001, 0, 2, 4'b0010, 16'h0030, 1, rc);
        do_access(1'b1, 1'b0, 16'h4034, 4'h0, 32'h00000099, 0, 0, 0, 32'h0, 0, 2, 4'b0010, 16'h0034, 1, rc2);
        chk("b2b_spacing", 32'(rc2 - rc), 32'h3);

        // saturating error counter
        for (int i = 0; i < 300; i++)
            do_access(1'b0, 1'b1, 16'hD000 + 16'(i * 4), 4'hF, 32'h0, 0, 0, 0, 32'h0, 1, 1, 4'h0, 16'h0, 0, rc);
        chk("err_cnt_sat", 32'(err_cnt), 32'hFF);
        chk("err_addr_last", 32'(err_addr), 32'hD4AC);

        // reset while slot 3 is being accessed
        rsp_silent = 1'b1;
        stray_en   = 1'b0;
        s.wr = 1'b0; s.vec = 4'b1000; s.sa = 16'h0010; s.be = 4'hF; s.wd = 32'h0;
        s.cyc = cyc + 1; s.len = -1;
        sq.push_back(s);
        addr = 16'hC010; be = 4'hF; wr_data = 32'h0; rd_req = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("pre_rst_s_rd_req", 32'(s_rd_req), 32'h8);
        #2;
        rstb   = 1'b0;
        rd_req = 1'b0;
        #1;
        chk("arst_s_rd_req", 32'(s_rd_req), 32'h0);
        chk("arst_ready", 32'({rd_ready, wr_ready, err}), 32'h0);
        chk("arst_s_addr", 32'(s_addr), 32'h0);
        chk("arst_s_be_wd", s_wr_data | 32'(s_be), 32'h0);
        chk("arst_err_cnt", 32'(err_cnt), 32'h0);
        chk("arst_err_addr", 32'(err_addr), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rstb = 1'b1;
        @(posedge clk);
        #1;
        do_access(1'b0, 1'b1, 16'hC014, 4'hF, 32'h0, 0, 0, 0, 32'h3C3C3C3C, 0, 2, 4'b1000, 16'h0014, 1, rc);

        repeat (3) @(posedge clk);
        #1;
        chk("rsp_q_empty", 32'(rsp_q.size()), 32'h0);
        chk("sreq_q_empty", 32'(sq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/d_bus_xbar.md
# d_bus_xbar

Parametrised single-master, N-slave data-bus decoder between the core's load/store port and its data-side targets (RAM, IO, peripheral banks). Each slave region is defined by a base/mask pair. The block runs every access through a small state machine: registered slave requests, a per-access timeout, error responses for unmapped or hung accesses, and an error capture register for software diagnosis.

## Interface
Parameters:
- XLEN, 32, data width; byte enables are XLEN/8 wide.
- ADDR_LEN, 16, master address width.
- N_SLV, 4, number of slave ports (1..8).
- SLV_BASE, N_SLV*ADDR_LEN packed, slot k base address; default 0 for every slot.
- SLV_MASK, N_SLV*ADDR_LEN packed, slot k decode mask; default all-ones for every slot.
- TIMEOUT, 255, maximum ACCESS cycles before an error response; 0 disables the timeout; 16-bit range.

Ports:
- clk  in  1  clock.
- rstb  in  1  reset; one clock, asynchronous, active-low.
- addr  in  ADDR_LEN  master byte address.
- rd_req / wr_req  in  1  master read / write request, held until the matching ready.
- be  in  XLEN/8  write byte enables.
- wr_data  in  XLEN  write data.
- rd_ready / wr_ready  out  1  one-cycle completion pulse.
- rd_data  out  XLEN  read data, valid while rd_ready=1.
- err  out  1  completion is an error, valid with the ready pulse.
- s_addr  out  ADDR_LEN  word-aligned offset inside the selected region.
- s_rd_req / s_wr_req  out  N_SLV  one-hot per-slave requests.
- s_be  out  XLEN/8  latched byte enables.
- s_wr_data  out  XLEN  latched write data.
- s_rd_data  in  N_SLV*XLEN  slave k read data in slice k.
- s_rd_ready / s_wr_ready  in  N_SLV  slave completion.
- err_addr  out  ADDR_LEN  address of the most recent errored access.
- err_cnt  out  8  saturating error count.

## Operation
- Decode: slot k hits when (addr & SLV_MASK[k]) == SLV_BASE[k]. The lowest hitting k wins. With no hit, the access is unmapped.
- Offset: s_addr = (addr & ~SLV_MASK[k]) with the low log2(XLEN/8) bits forced to 0.
- Op select: if rd_req and wr_req are both high, the write is performed; the read is ignored and produces no rd_ready.
- FSM states:
  - IDLE: on rd_req|wr_req, latch sel, op, s_addr, s_be, s_wr_data and addr.
    - Hit: go to ACCESS.
    - Miss: go to ERR.
  - ACCESS: s_rd_req[sel] or s_wr_req[sel] is high as a registered output; the timer increments each cycle.
    - Matching s_*_ready[sel]=1 (read): capture s_rd_data slice sel into the data register, drop the request, go to DONE.
    - Matching s_*_ready[sel]=1 (write): drop the request, go to DONE.
    - Else, TIMEOUT≠0 and timer==TIMEOUT-1: drop the request, go to ERR.
    - Ready arriving in the same cycle as the timeout limit wins: go to DONE.
  - DONE: pulse rd_ready or wr_ready for one cycle, err=0, rd_data from the data register; go to IDLE.
  - ERR: pulse the matching ready with err=1 and rd_data=0.
    - err_addr ← latched addr.
    - err_cnt += 1, saturating at 255.
    - Go to IDLE.
- Ready inputs from non-selected slaves, and any ready input outside ACCESS, are ignored.
- Master requests seen outside IDLE are not sampled. The master must drop or change its request in the cycle after the ready pulse; a request still high in IDLE is a new access.
- Writes with be=0 are forwarded unchanged.

## Timing
- Reset values: all outputs 0, including err_addr and err_cnt; the data register and timer are 0; state is IDLE.
- Reset mid-access drops s_*_req asynchronously and issues no master ready.
- Minimum latency, request in IDLE at cycle 0:
  - Slave request high at cycle 1.
  - If the slave is ready at cycle 1, master ready at cycle 2.
  - Each slave wait cycle adds one cycle.
- Unmapped access: ERR at cycle 1, so ready+err at cycle 1.
- Timeout: with a silent slave, the slave request is high for exactly TIMEOUT cycles (cycles 1..TIMEOUT). The error ready follows at cycle TIMEOUT+1.
- Back-to-back throughput: one access per 3 cycles when slaves answer immediately.
- rd_data and err are meaningful only while a ready is high; otherwise rd_data=0 and err=0.

## Test plan
- Read hit, zero wait: N_SLV=4, SLV_BASE[1]=0x4000, SLV_MASK[1]=0xC000; read 0x4008, slave1 returns 0xDEADBEEF same cycle → s_rd_req=4'b0010 and s_addr=0x0008 at cycle 1; rd_ready with rd_data=0xDEADBEEF and err=0 at cycle 2.
- Write with waits: write 0x4006, be=4'b1100, slave1 ready after 3 cycles → s_addr=0x0004, s_be=4'b1100 held throughout; wr_ready at cycle 5, single pulse.
- Unmapped access: read an address hitting no slot → rd_ready, err=1, rd_data=0 at cycle 1; err_addr=that address; err_cnt=1; no s_*_req ever asserted.
- Timeout: TIMEOUT=4, slave silent → s_wr_req high cycles 1-4; wr_ready+err at cycle 5. A ready from the same slave at cycle 4 instead gives a normal completion with err=0.
- Priority and collisions: overlapping slots 0 and 2 → slot 0 selected. Simultaneous rd_req+wr_req → only a write and wr_ready. Stray ready from an unselected slave → ignored. 300 errors → err_cnt=255.
- Reset mid-ACCESS: rstb low while s_rd_req[3]=1 → all outputs 0 immediately; after release, the next request is serviced normally.
